// File: rtl/sequencer.sv
// ---------------------------------------------------------------------------
// sequencer -- nibble-serial instruction sequencer for a 4-bit datapath.
//
// Fetches each instruction byte from program memory as two nibbles (high
// then low), latches opcode/operand, optionally fetches an 8-bit target byte,
// then issues one EXEC cycle of datapath control.
//
// Instruction timing:
//   1-byte : FETCH_HI, FETCH_LO, EXEC
//   2-byte : FETCH_HI, FETCH_LO, ADDR_HI, ADDR_LO, EXEC
//   HLT enters HALTED and stays there until reset.
//
// Parameter:
//   RESET_PC           program-counter value loaded on reset
//
// Configuration macro:
//   SEQUENCER_STACK_EN adds a 4-entry return stack with JMS (0xD, 2-byte)
//                      and BBL (0xE, 1-byte). Without it, 0xD/0xE are NOPs
//                      and no stack storage exists.
//
// Ports:
//   clock              sole clock, rising edge
//   reset              synchronous, active-high; overrides halt
//   halt               freeze: no state change, all write/clear strobes 0
//   rom_addr[7:0]      program-memory byte address (the PC)
//   rom_nibble         0 = high nibble, 1 = low nibble
//   data[3:0]          nibble from program memory, same cycle
//   take_branch        branch condition from the datapath; during ISZ EXEC
//                      it carries "register before increment != 4'hF"
//   reg_is_zero        datapath status, not used by this sequencer
//   clear_carry, write_carry, clear_accumulator, write_accumulator,
//   write_register     one-cycle strobes, EXEC only
//   inst_operand[3:0]  latched operand nibble
//   acc_input_sel[2:0], reg_input_sel[1:0], alu_op[1:0], alu_in0_sel[2:0],
//   alu_in1_sel[1:0], alu_cin_sel[1:0]   datapath selects (encodings below)
//   halted             high once HLT has executed
// ---------------------------------------------------------------------------
module sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       halt,
  output logic [7:0] rom_addr,
  output logic       rom_nibble,
  input  logic [3:0] data,
  input  logic       take_branch,
  input  logic       reg_is_zero,
  output logic       clear_carry,
  output logic       write_carry,
  output logic       clear_accumulator,
  output logic       write_accumulator,
  output logic [3:0] inst_operand,
  output logic [2:0] acc_input_sel,
  output logic       write_register,
  output logic [1:0] reg_input_sel,
  output logic [1:0] alu_op,
  output logic [2:0] alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic [1:0] alu_cin_sel,
  output logic       halted
);

  // Datapath select encodings shared with the datapath.
  localparam logic [2:0] ACC_SEL_ALU = 3'd0;
  localparam logic [2:0] ACC_SEL_IMM = 3'd1;
  localparam logic [2:0] ACC_SEL_REG = 3'd2;
  localparam logic [1:0] REG_SEL_ACC = 2'd0;
  localparam logic [1:0] REG_SEL_ALU = 2'd1;
  localparam logic [1:0] ALU_ADD     = 2'd0;
  localparam logic [1:0] ALU_SUB     = 2'd1;  // ALU inverts in1 internally
  localparam logic [2:0] IN0_ACC     = 3'd0;
  localparam logic [2:0] IN0_REG     = 3'd1;
  localparam logic [1:0] IN1_REG     = 2'd0;
  localparam logic [1:0] IN1_ZERO    = 2'd1;
  localparam logic [1:0] CIN_ZERO    = 2'd0;
  localparam logic [1:0] CIN_CARRY   = 2'd1;
  localparam logic [1:0] CIN_ONE     = 2'd2;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_LDM = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_ISZ = 4'h8;
  localparam logic [3:0] OP_JUN = 4'h9;
  localparam logic [3:0] OP_CLC = 4'hA;
  localparam logic [3:0] OP_CLB = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;
`ifdef SEQUENCER_STACK_EN
  localparam logic [3:0] OP_JMS = 4'hD;
  localparam logic [3:0] OP_BBL = 4'hE;
`endif

  typedef enum logic [2:0] {
    FETCH_HI = 3'd0,
    FETCH_LO = 3'd1,
    EXEC     = 3'd2,
    ADDR_HI  = 3'd3,
    ADDR_LO  = 3'd4,
    HALTED   = 3'd5
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [3:0] r_opcode;
  logic [3:0] r_operand;
  logic [7:0] r_target;
  logic       r_halted;

`ifdef SEQUENCER_STACK_EN
  logic [7:0] r_stack [4];
  logic [1:0] r_sp;
  logic [1:0] w_sp_dec;
  assign w_sp_dec = r_sp - 2'd1;
`endif

  logic w_two_byte;
  logic w_strobe_en;
  logic w_cc, w_wc, w_ca, w_wa, w_wr;
  logic w_unused_status;

  // reg_is_zero is part of the datapath contract but not consumed here.
  assign w_unused_status = reg_is_zero;

  // Instructions that carry a target byte after the opcode byte.
  always_comb begin
    w_two_byte = (r_opcode == OP_JCN) || (r_opcode == OP_ISZ) ||
                 (r_opcode == OP_JUN);
`ifdef SEQUENCER_STACK_EN
    if (r_opcode == OP_JMS) w_two_byte = 1'b1;
`endif
  end

  // -------------------------------------------------------------------------
  // Control FSM: fetch, target fetch, execute, halt.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= FETCH_HI;
      r_pc      <= RESET_PC;
      r_opcode  <= 4'h0;
      r_operand <= 4'h0;
      r_target  <= 8'h00;
      r_halted  <= 1'b0;
`ifdef SEQUENCER_STACK_EN
      r_sp      <= 2'd0;
`endif
    end else if (!halt) begin
      case (r_state)
        FETCH_HI: begin
          r_opcode <= data;
          r_state  <= FETCH_LO;
        end
        FETCH_LO: begin
          r_operand <= data;
          r_pc      <= r_pc + 8'd1;
          r_state   <= w_two_byte ? ADDR_HI : EXEC;
        end
        ADDR_HI: begin
          r_target[7:4] <= data;
          r_state       <= ADDR_LO;
        end
        ADDR_LO: begin
          r_target[3:0] <= data;
          r_pc          <= r_pc + 8'd1;
          r_state       <= EXEC;
        end
        EXEC: begin
          r_state <= FETCH_HI;
          case (r_opcode)
            OP_JCN: if (take_branch) r_pc <= r_target;
            // Datapath reports "pre-increment register != 4'hF" on take_branch.
            OP_ISZ: if (take_branch) r_pc <= r_target;
            OP_JUN: r_pc <= r_target;
            OP_HLT: begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end
`ifdef SEQUENCER_STACK_EN
            OP_JMS: begin
              r_stack[r_sp] <= r_pc;  // PC already points past the target byte
              r_sp          <= r_sp + 2'd1;
              r_pc          <= r_target;
            end
            OP_BBL: begin
              r_pc <= r_stack[w_sp_dec];
              r_sp <= w_sp_dec;
            end
`endif
            default: ;
          endcase
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= FETCH_HI;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // EXEC decode. Selects follow the opcode during EXEC; strobes are further
  // gated so that a halt or a reset landing on EXEC writes nothing.
  // -------------------------------------------------------------------------
  always_comb begin
    w_cc          = 1'b0;
    w_wc          = 1'b0;
    w_ca          = 1'b0;
    w_wa          = 1'b0;
    w_wr          = 1'b0;
    acc_input_sel = ACC_SEL_ALU;
    reg_input_sel = REG_SEL_ACC;
    alu_op        = ALU_ADD;
    alu_in0_sel   = IN0_ACC;
    alu_in1_sel   = IN1_REG;
    alu_cin_sel   = CIN_ZERO;
    if (r_state == EXEC) begin
      case (r_opcode)
        OP_NOP: ;
        OP_LDM: begin
          w_wa          = 1'b1;
          acc_input_sel = ACC_SEL_IMM;
        end
        OP_LD: begin
          w_wa          = 1'b1;
          acc_input_sel = ACC_SEL_REG;
        end
        OP_ST: begin
          w_wr          = 1'b1;
          reg_input_sel = REG_SEL_ACC;
        end
        OP_ADD: begin
          w_wa          = 1'b1;
          w_wc          = 1'b1;
          acc_input_sel = ACC_SEL_ALU;
          alu_op        = ALU_ADD;
          alu_in0_sel   = IN0_ACC;
          alu_in1_sel   = IN1_REG;
          alu_cin_sel   = CIN_CARRY;
        end
        OP_SUB: begin
          w_wa          = 1'b1;
          w_wc          = 1'b1;
          acc_input_sel = ACC_SEL_ALU;
          alu_op        = ALU_SUB;
          alu_in0_sel   = IN0_ACC;
          alu_in1_sel   = IN1_REG;
          alu_cin_sel   = CIN_CARRY;
        end
        OP_INC, OP_ISZ: begin
          // reg + 0 + 1, carry left alone
          w_wr          = 1'b1;
          reg_input_sel = REG_SEL_ALU;
          alu_op        = ALU_ADD;
          alu_in0_sel   = IN0_REG;
          alu_in1_sel   = IN1_ZERO;
          alu_cin_sel   = CIN_ONE;
        end
        OP_CLC: w_cc = 1'b1;
        OP_CLB: begin
          w_cc = 1'b1;
          w_ca = 1'b1;
        end
`ifdef SEQUENCER_STACK_EN
        OP_BBL: begin
          w_wa          = 1'b1;
          acc_input_sel = ACC_SEL_IMM;
        end
`endif
        default: ;
      endcase
    end
  end

  assign w_strobe_en       = ~halt & ~reset;
  assign clear_carry       = w_cc & w_strobe_en;
  assign write_carry       = w_wc & w_strobe_en;
  assign clear_accumulator = w_ca & w_strobe_en;
  assign write_accumulator = w_wa & w_strobe_en;
  assign write_register    = w_wr & w_strobe_en;

  assign rom_addr     = r_pc;
  assign rom_nibble   = (r_state == FETCH_LO) || (r_state == ADDR_LO);
  assign inst_operand = r_operand;
  assign halted       = r_halted;

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the nibble-serial sequencer. Program memory is a byte
// array answering combinationally with the nibble selected by rom_nibble.
module tb_sequencer;

  logic       clock;
  logic       reset;
  logic       halt;
  logic [7:0] rom_addr;
  logic       rom_nibble;
  logic [3:0] data;
  logic       take_branch;
  logic       reg_is_zero;
  logic       clear_carry, write_carry, clear_accumulator, write_accumulator;
  logic [3:0] inst_operand;
  logic [2:0] acc_input_sel;
  logic       write_register;
  logic [1:0] reg_input_sel;
  logic [1:0] alu_op;
  logic [2:0] alu_in0_sel;
  logic [1:0] alu_in1_sel;
  logic [1:0] alu_cin_sel;
  logic       halted;

  logic [7:0] rom [256];
  logic [7:0] cur_byte;
  logic [4:0] strobes;
  logic [18:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  sequencer #(.RESET_PC(8'h00)) dut (
    .clock(clock), .reset(reset), .halt(halt),
    .rom_addr(rom_addr), .rom_nibble(rom_nibble), .data(data),
    .take_branch(take_branch), .reg_is_zero(reg_is_zero),
    .clear_carry(clear_carry), .write_carry(write_carry),
    .clear_accumulator(clear_accumulator), .write_accumulator(write_accumulator),
    .inst_operand(inst_operand), .acc_input_sel(acc_input_sel),
    .write_register(write_register), .reg_input_sel(reg_input_sel),
    .alu_op(alu_op), .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel),
    .alu_cin_sel(alu_cin_sel), .halted(halted)
  );

  assign cur_byte = rom[rom_addr];
  assign data     = rom_nibble ? cur_byte[3:0] : cur_byte[7:4];
  assign strobes  = {clear_carry, write_carry, clear_accumulator,
                     write_accumulator, write_register};
  assign ctl      = {clear_carry, write_carry, clear_accumulator, write_accumulator,
                     write_register, acc_input_sel, reg_input_sel, alu_op,
                     alu_in0_sel, alu_in1_sel, alu_cin_sel};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  // Leaves the DUT in FETCH_HI at RESET_PC, reset released for the next edge.
  task automatic do_reset();
    halt = 1'b0;
    take_branch = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 8'h25;
    take_branch = 1'b0;
    halt  = 1'b1;   // reset must win over halt
    reset = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", rom_addr, 8'h00); end
    n_tests++; if (rom_nibble !== 1'b0) begin n_fail++; $display("FAIL reset_nibble: got %b expected 0", rom_nibble); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_tests++; if (inst_operand !== 4'h0) begin n_fail++; $display("FAIL reset_operand: got %h expected 0", inst_operand); end
    n_tests++; if (strobes !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00000", strobes); end
    reset = 1'b0;
    halt  = 1'b0;
  endtask

  task automatic test_ldm();
    clear_rom();
    rom[0] = 8'h25;
    do_reset();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL ldm_fetch_hi: got %h/%b expected 00/0", rom_addr, rom_nibble); end
    tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL ldm_fetch_lo: got %h/%b expected 00/1", rom_addr, rom_nibble); end
    tick();
    n_tests++; if (ctl !== {1'b0,1'b0,1'b0,1'b1,1'b0,3'd1,2'd0,2'd0,3'd0,2'd0,2'd0}) begin n_fail++; $display("FAIL ldm_exec_ctl: got %h", ctl); end
    n_tests++; if (inst_operand !== 4'h5) begin n_fail++; $display("FAIL ldm_operand: got %h expected 5", inst_operand); end
    n_tests++; if (rom_addr !== 8'h01) begin n_fail++; $display("FAIL ldm_pc: got %h expected 01", rom_addr); end
    tick();
    n_tests++; if ({rom_addr, rom_nibble, write_accumulator} !== {8'h01, 1'b0, 1'b0}) begin n_fail++; $display("FAIL ldm_next_fetch: got %h/%b/%b expected 01/0/0", rom_addr, rom_nibble, write_accumulator); end
  endtask

  task automatic test_jun();
    clear_rom();
    rom[0] = 8'h90; rom[1] = 8'h40;
    do_reset();
    tick(); tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL jun_addr_hi: got %h/%b expected 01/0", rom_addr, rom_nibble); end
    tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h01, 1'b1}) begin n_fail++; $display("FAIL jun_addr_lo: got %h/%b expected 01/1", rom_addr, rom_nibble); end
    tick();
    n_tests++; if ({rom_addr, strobes} !== {8'h02, 5'b0}) begin n_fail++; $display("FAIL jun_exec: got %h/%b expected 02/00000", rom_addr, strobes); end
    tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h40, 1'b0}) begin n_fail++; $display("FAIL jun_target: got %h/%b expected 40/0", rom_addr, rom_nibble); end
  endtask

  task automatic test_jcn();
    logic [7:0] exp;
    for (int tb = 0; tb < 2; tb++) begin
      clear_rom();
      rom[0] = 8'h12; rom[1] = 8'h80;
      do_reset();
      take_branch = tb[0];
      exp = tb[0] ? 8'h80 : 8'h02;
      repeat (4) tick();
      n_tests++; if (strobes !== 5'b0) begin n_fail++; $display("FAIL jcn_strobes: got %b expected 00000", strobes); end
      tick();
      n_tests++; if (rom_addr !== exp) begin n_fail++; $display("FAIL jcn_take%0d: got %h expected %h", tb, rom_addr, exp); end
    end
    take_branch = 1'b0;
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = 8'h90; rom[1] = 8'hFF; rom[255] = 8'h00;
    do_reset();
    repeat (5) tick();
    n_tests++; if (rom_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_jump: got %h expected ff", rom_addr); end
    repeat (3) tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL wrap_pc: got %h/%b expected 00/0", rom_addr, rom_nibble); end
  endtask

  task automatic test_decode();
    logic [7:0]  prog [7]  = '{8'h00, 8'h33, 8'h44, 8'h53, 8'h62, 8'h71, 8'hA0};
    logic [18:0] exp  [7];
    exp[0] = 19'd0;
    exp[1] = {1'b0,1'b0,1'b0,1'b1,1'b0,3'd2,2'd0,2'd0,3'd0,2'd0,2'd0};
    exp[2] = {1'b0,1'b0,1'b0,1'b0,1'b1,3'd0,2'd0,2'd0,3'd0,2'd0,2'd0};
    exp[3] = {1'b0,1'b1,1'b0,1'b1,1'b0,3'd0,2'd0,2'd0,3'd0,2'd0,2'd1};
    exp[4] = {1'b0,1'b1,1'b0,1'b1,1'b0,3'd0,2'd0,2'd1,3'd0,2'd0,2'd1};
    exp[5] = {1'b0,1'b0,1'b0,1'b0,1'b1,3'd0,2'd1,2'd0,3'd1,2'd1,2'd2};
    exp[6] = {1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,2'd0,2'd0,3'd0,2'd0,2'd0};
    for (int k = 0; k < 7; k++) begin
      clear_rom();
      rom[0] = prog[k];
      do_reset();
      tick(); tick();
      n_tests++; if (ctl !== exp[k]) begin n_fail++; $display("FAIL decode_%h: got %h expected %h", prog[k], ctl, exp[k]); end
    end
    // CLB clears both; 0xC is an unused opcode
    clear_rom();
    rom[0] = 8'hB0;
    do_reset();
    tick(); tick();
    n_tests++; if (strobes !== 5'b10100) begin n_fail++; $display("FAIL decode_clb: got %b expected 10100", strobes); end
    clear_rom();
    rom[0] = 8'hC3;
    do_reset();
    tick(); tick();
    n_tests++; if ({strobes, rom_addr} !== {5'b0, 8'h01}) begin n_fail++; $display("FAIL decode_c_nop: got %b/%h expected 00000/01", strobes, rom_addr); end
  endtask

  task automatic test_isz();
    logic [7:0] exp;
    for (int tb = 0; tb < 2; tb++) begin
      clear_rom();
      rom[0] = 8'h85; rom[1] = 8'h30;
      do_reset();
      take_branch = tb[0];
      exp = tb[0] ? 8'h30 : 8'h02;
      repeat (4) tick();
      n_tests++; if (ctl !== {1'b0,1'b0,1'b0,1'b0,1'b1,3'd0,2'd1,2'd0,3'd1,2'd1,2'd2}) begin n_fail++; $display("FAIL isz_ctl: got %h", ctl); end
      tick();
      n_tests++; if (rom_addr !== exp) begin n_fail++; $display("FAIL isz_branch%0d: got %h expected %h", tb, rom_addr, exp); end
    end
    take_branch = 1'b0;
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 8'h90; rom[1] = 8'h40;
    do_reset();
    tick(); tick();           // ADDR_HI
    halt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++; if ({rom_addr, rom_nibble, strobes} !== {8'h01, 1'b0, 5'b0}) begin n_fail++; $display("FAIL halt_hold%0d: got %h/%b/%b expected 01/0/00000", c, rom_addr, rom_nibble, strobes); end
    end
    halt = 1'b0;
    tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h01, 1'b1}) begin n_fail++; $display("FAIL halt_resume: got %h/%b expected 01/1", rom_addr, rom_nibble); end
    tick(); tick();
    n_tests++; if (rom_addr !== 8'h40) begin n_fail++; $display("FAIL halt_complete: got %h expected 40", rom_addr); end
    // halt landing on EXEC suppresses the write until it falls
    clear_rom();
    rom[0] = 8'h25;
    do_reset();
    tick(); tick();
    halt = 1'b1;
    #1;
    n_tests++; if (write_accumulator !== 1'b0) begin n_fail++; $display("FAIL halt_exec_gate: got %b expected 0", write_accumulator); end
    tick();
    n_tests++; if ({write_accumulator, rom_addr} !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL halt_exec_hold: got %b/%h expected 0/01", write_accumulator, rom_addr); end
    halt = 1'b0;
    #1;
    n_tests++; if (write_accumulator !== 1'b1) begin n_fail++; $display("FAIL halt_exec_release: got %b expected 1", write_accumulator); end
    tick();
    n_tests++; if ({rom_addr, rom_nibble, write_accumulator} !== {8'h01, 1'b0, 1'b0}) begin n_fail++; $display("FAIL halt_exec_next: got %h/%b/%b expected 01/0/0", rom_addr, rom_nibble, write_accumulator); end
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = 8'h25;
    do_reset();
    tick(); tick();           // EXEC of LDM
    reset = 1'b1;
    #1;
    n_tests++; if (strobes !== 5'b0) begin n_fail++; $display("FAIL rstmid_strobes: got %b expected 00000", strobes); end
    tick();
    reset = 1'b0;
    n_tests++; if ({rom_addr, rom_nibble, inst_operand} !== {8'h00, 1'b0, 4'h0}) begin n_fail++; $display("FAIL rstmid_state: got %h/%b/%h expected 00/0/0", rom_addr, rom_nibble, inst_operand); end
  endtask

  task automatic test_hlt();
    clear_rom();
    rom[0] = 8'hF0;
    do_reset();
    tick(); tick();
    n_tests++; if ({halted, strobes} !== {1'b0, 5'b0}) begin n_fail++; $display("FAIL hlt_exec: got %b/%b expected 0/00000", halted, strobes); end
    tick();
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL hlt_set: got %b expected 1", halted); end
    repeat (5) tick();
    n_tests++; if ({halted, rom_addr, rom_nibble} !== {1'b1, 8'h01, 1'b0}) begin n_fail++; $display("FAIL hlt_stay: got %b/%h/%b expected 1/01/0", halted, rom_addr, rom_nibble); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if ({halted, rom_addr} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL hlt_reset: got %b/%h expected 0/00", halted, rom_addr); end
  endtask

  task automatic test_stack();
`ifdef SEQUENCER_STACK_EN
    clear_rom();
    rom[8'h00] = 8'h90; rom[8'h01] = 8'h10;
    rom[8'h10] = 8'hD0; rom[8'h11] = 8'h20;
    rom[8'h20] = 8'hE7;
    do_reset();
    repeat (5) tick();
    n_tests++; if (rom_addr !== 8'h10) begin n_fail++; $display("FAIL stack_jun: got %h expected 10", rom_addr); end
    repeat (4) tick();
    n_tests++; if (strobes !== 5'b0) begin n_fail++; $display("FAIL stack_jms_exec: got %b expected 00000", strobes); end
    tick();
    n_tests++; if (rom_addr !== 8'h20) begin n_fail++; $display("FAIL stack_jms: got %h expected 20", rom_addr); end
    tick(); tick();
    n_tests++; if ({write_accumulator, acc_input_sel, inst_operand} !== {1'b1, 3'd1, 4'h7}) begin n_fail++; $display("FAIL stack_bbl_exec: got %b/%h/%h expected 1/1/7", write_accumulator, acc_input_sel, inst_operand); end
    tick();
    n_tests++; if (rom_addr !== 8'h12) begin n_fail++; $display("FAIL stack_bbl_ret: got %h expected 12", rom_addr); end
`else
    clear_rom();
    rom[0] = 8'hD0; rom[1] = 8'hE5;
    do_reset();
    tick(); tick();
    n_tests++; if (strobes !== 5'b0) begin n_fail++; $display("FAIL nostack_d_exec: got %b expected 00000", strobes); end
    tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL nostack_d_1byte: got %h/%b expected 01/0", rom_addr, rom_nibble); end
    tick(); tick();
    n_tests++; if (strobes !== 5'b0) begin n_fail++; $display("FAIL nostack_e_exec: got %b expected 00000", strobes); end
    tick();
    n_tests++; if ({rom_addr, rom_nibble} !== {8'h02, 1'b0}) begin n_fail++; $display("FAIL nostack_e_next: got %h/%b expected 02/0", rom_addr, rom_nibble); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    halt = 1'b0;
    take_branch = 1'b0;
    reg_is_zero = 1'b0;
    clear_rom();
    test_reset();
    test_ldm();
    test_jun();
    test_jcn();
    test_wrap();
    test_decode();
    test_isz();
    test_halt();
    test_reset_mid();
    test_hlt();
    test_stack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
